ram_stream_reader: RTL

- Reader for the dual-port RAM: drives its read-only port B to stream a contiguous block of words out on a valid/ready interface.
- Writers fill the RAM through port A. A controller then issues start, base and length, and this block delivers the words in address order to the downstream consumer.
- Absorbs the RAM's 1-cycle registered read latency and downstream backpressure with a 2-entry output buffer.

---
 rtl/ram_stream_reader.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: streams a contiguous RAM block from port B onto a valid/ready interface.
// Rev 1.0 - initial release.
`default_nettype none

module ram_stream_reader #(
  parameter int ADDR_SIZE = 4,
  parameter int DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDR_SIZE-1:0] base_addr,
  input  logic [ADDR_SIZE:0]   length,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_SIZE-1:0] ram_addr,
  input  logic [DATA_SIZE-1:0] ram_data,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [ADDR_SIZE:0]   remaining;
  logic [ADDR_SIZE:0]   to_pop;
  logic [1:0]           occ;
  logic                 inflight;
  logic [DATA_SIZE-1:0] buf0, buf1;
  logic                 pop, issue, accept, zero_start, last_pop;

  assign pop       = out_valid & out_ready;
  assign out_valid = (occ != 2'd0);
  assign out_data  = buf0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    accept     = 1'b0;
    zero_start = 1'b0;
    last_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            accept    = 1'b1;
            state_nxt = READ;
          end else begin
            zero_start = 1'b1;
          end
        end
      end
      READ: begin
        if (remaining == '0) begin
          state_nxt = DRAIN;
        end else if (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop})) begin
          // Credit: buffered + in-flight words after this cycle's pop must leave room.
          issue = 1'b1;
        end
      end
      DRAIN: begin
        if (pop && (to_pop == {{ADDR_SIZE{1'b0}}, 1'b1})) begin
          last_pop  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done      <= 1'b0;
      ram_addr  <= '0;
      remaining <= '0;
      to_pop    <= '0;
      inflight  <= 1'b0;
      occ       <= 2'd0;
      buf0      <= '0;
      buf1      <= '0;
    end else begin
      done     <= zero_start | last_pop;
      inflight <= issue;
      if (accept) begin
        ram_addr  <= base_addr;
        remaining <= length;
        to_pop    <= length;
      end else begin
        if (issue) begin
          ram_addr  <= ram_addr + 1'b1;
          remaining <= remaining - 1'b1;
        end
        if (pop && (to_pop != '0)) to_pop <= to_pop - 1'b1;
      end

      // buf0 is always the head; buf1 only holds a second word when occ==2.
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) buf0 <= ram_data;
          else             buf1 <= ram_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf0 <= ram_data;
          end else begin
            buf0 <= buf1;
            buf1 <= ram_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
